izh_neuron_scheduler: RTL
=========================

Name: izh_neuron_scheduler

Overview:
- Time-multiplexes one external izhikevich update datapath across NUM_NEURONS neurons.
- Holds per-neuron v/u state in an internal register file. Sweeps every neuron once per timestep on a step_start pulse and writes back v_prime/u_prime.
- Emits one spike event per fired neuron over a valid/ready handshake.
- Sits between the host/timestep controller, the synaptic current accumulator (cur_*) and the izhikevich datapath (dp_*).

Parameters:
- NUM_NEURONS, 16: neurons served; must be ≥2.
- IDX_W, 4: index width; must equal clog2(NUM_NEURONS).
- V_INIT, 17'h1_4100: reset value of every v entry (−65.0, sign-magnitude 1.8.8).
- U_INIT, 17'h1_0D00: reset value of every u entry (−13.0).

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- step_start  in  1  start one timestep sweep; honoured only in IDLE
- busy  out  1  sweep in progress
- step_done  out  1  one-cycle pulse at sweep end
- cfg_a, cfg_b, cfg_c, cfg_d  in  17 each  model parameters, passed straight to dp_a..dp_d
- cur_idx  out  IDX_W  neuron whose current is requested
- cur_i  in  17  input current for cur_idx; combinational, same cycle
- dp_a, dp_b, dp_c, dp_d, dp_v, dp_u, dp_i  out  17 each  datapath operands
- dp_v_prime, dp_u_prime  in  17 each  datapath results, registered in datapath (latency 1)
- dp_fired  in  1  datapath fire flag, latency 1
- spike_valid  out  1  spike event pending
- spike_idx  out  IDX_W  index of fired neuron
- spike_ready  in  1  consumer accepts spike
- wr_en  in  1  host state write; ignored while busy
- wr_idx  in  IDX_W  host write index
- wr_v, wr_u  in  17 each  host write data

Behaviour:
- Reset:
  - FSM=IDLE; busy=0, step_done=0, spike_valid=0, spike_idx=0, cur_idx=0.
  - All v entries=V_INIT, all u entries=V_INIT's pair U_INIT.
  - rst mid-sweep aborts the sweep: no step_done, pending spike dropped.
- FSM states: IDLE, ISSUE, CAPTURE, SPIKE, DONE.
- IDLE:
  - step_start=1 → ISSUE, idx=0.
  - wr_en writes v[wr_idx]/u[wr_idx] in IDLE only; wr_idx ≥ NUM_NEURONS is ignored.
- ISSUE:
  - Drive cur_idx=idx, dp_v=v[idx], dp_u=u[idx], dp_i=cur_i.
  - dp_* are don't-care outside ISSUE but held stable at last values.
  - → CAPTURE.
- CAPTURE:
  - Write v[idx]←dp_v_prime, u[idx]←dp_u_prime.
  - If dp_fired: latch spike_idx=idx → SPIKE.
  - Else if idx==NUM_NEURONS−1 → DONE.
  - Else idx+1 → ISSUE.
- SPIKE:
  - spike_valid=1; spike_idx stable until accepted.
  - On spike_valid&&spike_ready: go to DONE if last index, else idx+1 → ISSUE.
  - spike_valid drops the cycle after acceptance.
- DONE: step_done=1 for one cycle → IDLE.
- busy=1 in ISSUE, CAPTURE, SPIKE and DONE.
- step_start outside IDLE is ignored (no queueing).
- Timing, no spikes, N neurons, step_start sampled at cycle 0:
  - ISSUE at cycles 1, 3, …, 2N−1; CAPTURE at 2, 4, …, 2N.
  - step_done at 2N+1; busy high cycles 1..2N+1.
- Each spike adds ≥1 cycle, plus the cycles spike_ready is low.
- Arithmetic: the scheduler does none; it only moves 17-bit words. Index increment is IDX_W bits and never wraps past NUM_NEURONS−1.

Optional Feature:
- Macro IZH_SCHED_SPIKE_CNT_EN.
- Defined:
  - Adds output spike_count [IDX_W:0], cleared on rst and on the accepted step_start.
  - Increments on each spike handshake; holds its value after step_done until the next step_start.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package izh_pkg:
  - IZH_W=17 and the fixed-point constants V_INIT/U_INIT.
  - FSM state enum izh_sched_state_t.
- Natural sub-module izh_state_rf:
  - NUM_NEURONS×2×17 register file.
  - Reset-to-init, one async read port (idx), one write port muxed between CAPTURE writeback and host write.

Test Plan:
- Reset then step_start, N=4, dp_fired=0, dp_v_prime=idx+1 → step_done at cycle 9; v[0..3]=1..4; spike_valid never high.
- Datapath fires on idx 2 only, spike_ready=1 → exactly one spike with spike_idx=2; step_done at cycle 10.
- Fire on idx 1, spike_ready held low 5 cycles → spike_valid and spike_idx=1 stable all 5 cycles; idx 2 not issued until acceptance.
- Host write wr_idx=3, wr_v=17'h0_1E00 in IDLE → dp_v=17'h0_1E00 when cur_idx=3. Same write while busy → no change.
- step_start re-pulsed mid-sweep → ignored, single step_done. rst at cycle 4 → busy=0 next cycle, all v=V_INIT, no step_done.
- With IZH_SCHED_SPIKE_CNT_EN, fire on 3 of 4 neurons → spike_count=3 after step_done; 0 after next step_start.

Source files
------------

// File: rtl/izh_pkg.sv
// Shared word width, fixed-point init constants and scheduler state encoding
// for the Izhikevich neuron scheduler slice.
package izh_pkg;

  localparam int IZH_W = 17;

  // Sign-magnitude 1.8.8: -65.0 and -13.0
  localparam logic [IZH_W-1:0] IZH_V_INIT = 17'h1_4100;
  localparam logic [IZH_W-1:0] IZH_U_INIT = 17'h1_0D00;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SPIKE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_ISSUE   = S_ISSUE,
    ST_CAPTURE = S_CAPTURE,
    ST_SPIKE   = S_SPIKE,
    ST_DONE    = S_DONE
  } izh_sched_state_t;

endpackage

// File: rtl/izh_state_rf.sv
// Per-neuron v/u register file: synchronous reset to the resting state,
// one combinational read port and one write port.
module izh_state_rf
  import izh_pkg::*;
#(
  parameter int               NUM_NEURONS = 16,
  parameter int               IDX_W       = 4,
  parameter logic [IZH_W-1:0] V_INIT      = IZH_V_INIT,
  parameter logic [IZH_W-1:0] U_INIT      = IZH_U_INIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [IZH_W-1:0] rd_v,
  output logic [IZH_W-1:0] rd_u,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [IZH_W-1:0] wr_v,
  input  logic [IZH_W-1:0] wr_u
);

  logic [IZH_W-1:0] v_q [NUM_NEURONS];
  logic [IZH_W-1:0] u_q [NUM_NEURONS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        v_q[n] <= V_INIT;
        u_q[n] <= U_INIT;
      end
    end else if (we) begin
      v_q[wr_idx] <= wr_v;
      u_q[wr_idx] <= wr_u;
    end
  end

  assign rd_v = v_q[rd_idx];
  assign rd_u = u_q[rd_idx];

endmodule

// File: rtl/izh_neuron_scheduler.sv
// Sweeps NUM_NEURONS neurons through one shared Izhikevich datapath per step.
// Optional spike counter output enabled by `define IZH_SCHED_SPIKE_CNT_EN.
module izh_neuron_scheduler
  import izh_pkg::*;
#(
  parameter int               NUM_NEURONS = 16,
  parameter int               IDX_W       = 4,
  parameter logic [IZH_W-1:0] V_INIT      = IZH_V_INIT,
  parameter logic [IZH_W-1:0] U_INIT      = IZH_U_INIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_start,
  output logic             busy,
  output logic             step_done,
  input  logic [16:0]      cfg_a,
  input  logic [16:0]      cfg_b,
  input  logic [16:0]      cfg_c,
  input  logic [16:0]      cfg_d,
  output logic [IDX_W-1:0] cur_idx,
  input  logic [16:0]      cur_i,
  output logic [16:0]      dp_a,
  output logic [16:0]      dp_b,
  output logic [16:0]      dp_c,
  output logic [16:0]      dp_d,
  output logic [16:0]      dp_v,
  output logic [16:0]      dp_u,
  output logic [16:0]      dp_i,
  input  logic [16:0]      dp_v_prime,
  input  logic [16:0]      dp_u_prime,
  input  logic             dp_fired,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx,
  input  logic             spike_ready,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [16:0]      wr_v,
  input  logic [16:0]      wr_u
`ifdef IZH_SCHED_SPIKE_CNT_EN
  , output logic [IDX_W:0] spike_count
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W+1)'(NUM_NEURONS);

  izh_sched_state_t state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] spike_idx_q;
  logic [16:0]      hold_v_q, hold_u_q, hold_i_q;

  logic             st_issue, st_capture, st_idle, is_last;
  logic             host_we, rf_we;
  logic [IDX_W-1:0] rf_widx;
  logic [16:0]      rf_wv, rf_wu, rf_rv, rf_ru;
  logic             spike_hs;

  assign st_idle    = (state_q == ST_IDLE);
  assign st_issue   = (state_q == ST_ISSUE);
  assign st_capture = (state_q == ST_CAPTURE);
  assign is_last    = (idx_q == LAST_IDX);

  // Host writes land only while idle; a capture never coincides with one.
  assign host_we = st_idle && wr_en && ({1'b0, wr_idx} < NUM_EXT);
  assign rf_we   = st_capture || host_we;
  assign rf_widx = st_capture ? idx_q      : wr_idx;
  assign rf_wv   = st_capture ? dp_v_prime : wr_v;
  assign rf_wu   = st_capture ? dp_u_prime : wr_u;

  izh_state_rf #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W),
    .V_INIT      (V_INIT),
    .U_INIT      (U_INIT)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (idx_q),
    .rd_v   (rf_rv),
    .rd_u   (rf_ru),
    .we     (rf_we),
    .wr_idx (rf_widx),
    .wr_v   (rf_wv),
    .wr_u   (rf_wu)
  );

  // Spike handshake: spike_valid/spike_idx stay asserted and stable until the
  // cycle where spike_valid && spike_ready; the event transfers on that edge.
  assign spike_valid = (state_q == ST_SPIKE);
  assign spike_idx   = spike_idx_q;
  assign spike_hs    = spike_valid && spike_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      spike_idx_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (step_start) begin
            state_q <= ST_ISSUE;
            idx_q   <= '0;
          end
        end
        ST_ISSUE: state_q <= ST_CAPTURE;
        ST_CAPTURE: begin
          if (dp_fired) begin
            spike_idx_q <= idx_q;
            state_q     <= ST_SPIKE;
          end else if (is_last) begin
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= ST_ISSUE;
          end
        end
        ST_SPIKE: begin
          if (spike_ready) begin
            if (is_last) begin
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Operands are live during ISSUE and frozen at those values otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q <= '0;
      hold_u_q <= '0;
      hold_i_q <= '0;
    end else if (st_issue) begin
      hold_v_q <= rf_rv;
      hold_u_q <= rf_ru;
      hold_i_q <= cur_i;
    end
  end

  assign dp_v = st_issue ? rf_rv : hold_v_q;
  assign dp_u = st_issue ? rf_ru : hold_u_q;
  assign dp_i = st_issue ? cur_i : hold_i_q;
  assign dp_a = cfg_a;
  assign dp_b = cfg_b;
  assign dp_c = cfg_c;
  assign dp_d = cfg_d;

  assign cur_idx   = idx_q;
  assign busy      = !st_idle;
  assign step_done = (state_q == ST_DONE);

`ifdef IZH_SCHED_SPIKE_CNT_EN
  logic [IDX_W:0] spike_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_cnt_q <= '0;
    end else if (st_idle && step_start) begin
      spike_cnt_q <= '0;
    end else if (spike_hs) begin
      spike_cnt_q <= spike_cnt_q + (IDX_W+1)'(1);
    end
  end

  assign spike_count = spike_cnt_q;
`else
  logic unused_hs;
  assign unused_hs = spike_hs;
`endif

endmodule
